hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 16-bit MIPS core. It sits beside the dependency check block and gates the PC and the IF/ID register. It inserts a one-cycle bubble on a load-use hazard, squashes wrong-path instructions after jumps and taken conditional jumps, and drains the pipeline into a halted state on request. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Purpose: pipeline sequencing for the 16-bit MIPS core (load-use bubble, jump/branch squash, halt drain, stall counter).
// Latency: hazard/flush/bubble decisions are combinational in the decode cycle; FSM and counters update on the next edge.
// Backpressure: stalls the front end by dropping pc_en/if_id_en; no valid/ready handshake on this block.
module hazard_ctrl #(
    parameter int JMP_FLUSH = 1,   // FLUSH-state cycles after a decoded jmp (1..3)
    parameter int BR_FLUSH  = 2,   // FLUSH-state cycles after br_taken (1..3)
    parameter int DRAIN     = 4    // DRAIN-state cycles before halt_ack (1..15)
) (
    input  logic        clk,
    input  logic        reset,        // synchronous, active low
    input  logic [31:0] ins,
    input  logic        br_taken,
    input  logic        halt_req,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        bubble,
    output logic        flush,
    output logic        halt_ack,
    output logic [2:0]  state,
    output logic [15:0] stall_cnt
);

    // State encoding is visible on the debug port, so the codes are fixed.
    localparam logic [2:0] S_RUN    = 3'd0;
    localparam logic [2:0] S_FLUSH  = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_HALTED = 3'd3;

    localparam logic [5:0] OP_LD  = 6'b010100;
    localparam logic [5:0] OP_JMP = 6'b011000;

    // Counters are loaded with (cycles - 1) and the FSM leaves when they read zero,
    // so the FLUSH/DRAIN states last exactly the parameterised number of cycles.
    localparam logic [1:0] JMP_LOAD   = 2'(JMP_FLUSH - 1);
    localparam logic [1:0] BR_LOAD    = 2'(BR_FLUSH - 1);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN - 1);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // ------------------------------------------------------------------
    // Decode of the instruction sitting in ID
    // ------------------------------------------------------------------
    logic [5:0] opcode;
    logic [4:0] rd_f;
    logic [4:0] ra_f;
    logic [4:0] rb_f;
    logic       is_ld;
    logic       is_jmp;
    logic       is_cond_j;
    logic       is_consumer;
    logic       unused_ins_bits;

    assign opcode    = ins[31:26];
    assign rd_f      = ins[25:21];
    assign ra_f      = ins[20:16];
    assign rb_f      = ins[15:11];
    assign is_ld     = (opcode == OP_LD);
    assign is_jmp    = (opcode == OP_JMP);
    assign is_cond_j = (opcode[4:2] == 3'b111) && !opcode[5];
    // Jumps carry an address/offset in the A/B fields, so they never read registers.
    assign is_consumer = !(is_jmp || is_cond_j);
    // Immediate/function bits do not take part in sequencing decisions.
    assign unused_ins_bits = ^ins[10:0];

    // ------------------------------------------------------------------
    // EX-stage tracker and hazard detection
    // ------------------------------------------------------------------
    logic       ex_ld_q;
    logic [4:0] ex_rd_q;
    logic       haz;

    // r0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign haz = ex_ld_q && is_consumer && (ex_rd_q != 5'd0) &&
                 ((ra_f == ex_rd_q) || (rb_f == ex_rd_q));

    // Track whether the instruction leaving ID is a load; anything squashed or
    // bubbled (or decoded outside RUN) never reaches EX, so it must not hazard.
    always_ff @(posedge clk) begin
        if (!reset || bubble || flush || (state != S_RUN)) begin
            ex_ld_q <= 1'b0;
            ex_rd_q <= 5'd0;
        end else begin
            ex_ld_q <= is_ld;
            ex_rd_q <= rd_f;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    logic [2:0] state_nxt;
    logic [1:0] fcnt;
    logic [1:0] fcnt_nxt;
    logic [3:0] dcnt;
    logic [3:0] dcnt_nxt;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_RUN;
            fcnt  <= 2'd0;
            dcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    // Next-state selection; only the highest-priority event is honoured
    // (br_taken, then load-use, then jmp, then halt_req).
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        dcnt_nxt  = dcnt;
        case (state)
            S_RUN: begin
                if (br_taken) begin
                    state_nxt = S_FLUSH;
                    fcnt_nxt  = BR_LOAD;
                end else if (haz) begin
                    state_nxt = S_RUN;
                end else if (is_jmp) begin
                    state_nxt = S_FLUSH;
                    fcnt_nxt  = JMP_LOAD;
                end else if (halt_req) begin
                    state_nxt = S_DRAIN;
                    dcnt_nxt  = DRAIN_LOAD;
                end
            end
            S_FLUSH: begin
                // A second taken branch restarts the squash window.
                if (br_taken) begin
                    fcnt_nxt = BR_LOAD;
                end else if (fcnt == 2'd0) begin
                    state_nxt = S_RUN;
                end else begin
                    fcnt_nxt = fcnt - 2'd1;
                end
            end
            S_DRAIN: begin
                // br_taken is ignored: everything is being bubbled already.
                if (!halt_req) begin
                    state_nxt = S_RUN;
                end else if (dcnt == 4'd0) begin
                    state_nxt = S_HALTED;
                end else begin
                    dcnt_nxt = dcnt - 4'd1;
                end
            end
            S_HALTED: begin
                if (!halt_req) begin
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    // Output decode; reset and illegal codes fall back to a held, bubbling pipe.
    always_comb begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        bubble   = 1'b1;
        flush    = 1'b0;
        halt_ack = 1'b0;
        if (reset) begin
            case (state)
                S_RUN: begin
                    if (br_taken) begin
                        // Redirect fetch, squash IF/ID and kill the ID instruction.
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                        bubble   = 1'b1;
                        flush    = 1'b1;
                    end else if (haz) begin
                        // Hold PC and IF/ID for one cycle and insert a NOP into EX.
                        pc_en    = 1'b0;
                        if_id_en = 1'b0;
                        bubble   = 1'b1;
                    end else if (is_jmp) begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                        bubble   = 1'b0;
                        flush    = 1'b1;
                    end else if (halt_req) begin
                        // Fetch stops immediately; the drain starts this cycle.
                        pc_en    = 1'b0;
                        if_id_en = 1'b0;
                        bubble   = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                        bubble   = 1'b0;
                    end
                end
                S_FLUSH: begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                    flush    = 1'b1;
                    bubble   = br_taken;
                end
                S_DRAIN: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    bubble   = 1'b1;
                end
                S_HALTED: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    bubble   = 1'b1;
                    halt_ack = 1'b1;
                end
                default: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    bubble   = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stall-cycle counter
    // ------------------------------------------------------------------
    // Count cycles with the PC frozen, excluding the parked HALTED state; saturate.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
        end else if (!pc_en && (state != S_HALTED) && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: randomized + directed scoreboard bench for hazard_ctrl against a behavioural model.
// Latency: one expected vector per clock, compared on the falling edge of the same cycle.
// Backpressure: none; the monitor pops one entry per cycle while the queue is non-empty.
module tb_hazard_ctrl;

    localparam int JF = 1;
    localparam int BF = 2;
    localparam int DR = 4;

    localparam logic [5:0] OP_LD  = 6'b010100;
    localparam logic [5:0] OP_ST  = 6'b010101;
    localparam logic [5:0] OP_JMP = 6'b011000;
    localparam logic [5:0] OP_CJ  = 6'b011100;
    localparam logic [5:0] OP_ALU = 6'b000001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ins = 32'd0;
    logic        br_taken = 1'b0;
    logic        halt_req = 1'b0;
    logic        pc_en;
    logic        if_id_en;
    logic        bubble;
    logic        flush;
    logic        halt_ack;
    logic [2:0]  state;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.JMP_FLUSH(JF), .BR_FLUSH(BF), .DRAIN(DR)) dut (
        .clk       (clk),
        .reset     (reset),
        .ins       (ins),
        .br_taken  (br_taken),
        .halt_req  (halt_req),
        .pc_en     (pc_en),
        .if_id_en  (if_id_en),
        .bubble    (bubble),
        .flush     (flush),
        .halt_ack  (halt_ack),
        .state     (state),
        .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic        pc_en;
        logic        if_id_en;
        logic        bubble;
        logic        flush;
        logic        halt_ack;
        logic [2:0]  state;
        logic [15:0] stall_cnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: mode 0 run, 1 squashing, 2 draining, 3 halted.
    int m_mode   = 0;
    int m_fleft  = 0;
    int m_dleft  = 0;
    int m_stalls = 0;
    bit m_exld   = 1'b0;
    int m_exrd   = 0;

    function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rd, logic [4:0] a, logic [4:0] b);
        return {op, rd, a, b, 11'h000};
    endfunction

    // Returns the outputs expected during this cycle and advances the model to the next edge.
    function automatic obs_t model_step(bit rst_n, logic [31:0] i, bit br, bit hr);
        obs_t       o;
        logic [5:0] op;
        bit         ld, jp, cj, reads, haz;
        int         rd, a, b, nmode;
        op    = i[31:26];
        rd    = int'(i[25:21]);
        a     = int'(i[20:16]);
        b     = int'(i[15:11]);
        ld    = (op == OP_LD);
        jp    = (op == OP_JMP);
        cj    = (op[4:2] == 3'b111) && !op[5];
        reads = !(jp || cj);
        haz   = m_exld && reads && (m_exrd != 0) && (a == m_exrd || b == m_exrd);
        o           = '0;
        o.state     = 3'(m_mode);
        o.stall_cnt = 16'(m_stalls);
        if (!rst_n) begin
            o.bubble = 1'b1;
            m_mode = 0; m_fleft = 0; m_dleft = 0; m_stalls = 0; m_exld = 1'b0; m_exrd = 0;
            return o;
        end
        nmode = m_mode;
        if (m_mode == 0) begin
            if (br) begin
                o.pc_en = 1; o.if_id_en = 1; o.bubble = 1; o.flush = 1;
                nmode = 1; m_fleft = BF - 1;
            end else if (haz) begin
                o.bubble = 1;
            end else if (jp) begin
                o.pc_en = 1; o.if_id_en = 1; o.flush = 1;
                nmode = 1; m_fleft = JF - 1;
            end else if (hr) begin
                o.bubble = 1;
                nmode = 2; m_dleft = DR - 1;
            end else begin
                o.pc_en = 1; o.if_id_en = 1;
            end
        end else if (m_mode == 1) begin
            o.pc_en = 1; o.if_id_en = 1; o.flush = 1; o.bubble = br;
            if (br) m_fleft = BF - 1;
            else if (m_fleft == 0) nmode = 0;
            else m_fleft--;
        end else if (m_mode == 2) begin
            o.bubble = 1;
            if (!hr) nmode = 0;
            else if (m_dleft == 0) nmode = 3;
            else m_dleft--;
        end else begin
            o.bubble = 1; o.halt_ack = 1;
            if (!hr) nmode = 0;
        end
        if (!o.pc_en && m_mode != 3 && m_stalls < 65535) m_stalls++;
        if (o.bubble || o.flush || m_mode != 0) begin
            m_exld = 1'b0; m_exrd = 0;
        end else begin
            m_exld = ld; m_exrd = rd;
        end
        m_mode = nmode;
        return o;
    endfunction

    // Drive one cycle of stimulus just after the edge and queue its expectation.
    task automatic cycle(input bit rst_n, input logic [31:0] i, input bit br, input bit hr);
        @(posedge clk);
        #1;
        reset    = rst_n;
        ins      = i;
        br_taken = br;
        halt_req = hr;
        exp_q.push_back(model_step(rst_n, i, br, hr));
    endtask

    // Monitor: outputs are valid every cycle; compare on the falling edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pc_en, if_id_en, bubble, flush, halt_ack, state, stall_cnt};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got pc=%b ifid=%b bub=%b fl=%b ack=%b st=%0d cnt=%0d, expected pc=%b ifid=%b bub=%b fl=%b ack=%b st=%0d cnt=%0d",
                             $time, a.pc_en, a.if_id_en, a.bubble, a.flush, a.halt_ack, a.state, a.stall_cnt,
                             e.pc_en, e.if_id_en, e.bubble, e.flush, e.halt_ack, e.state, e.stall_cnt);
                end
            end
        end
    end

    initial begin
        logic [31:0] nop;
        logic [31:0] ri;
        logic [5:0]  rop;
        bit          rhr;
        nop = mk(OP_ALU, 5'd0, 5'd0, 5'd0);

        // Reset and first RUN cycle.
        repeat (3) cycle(0, nop, 0, 0);
        repeat (2) cycle(1, nop, 0, 0);

        // Load-use on A, held consumer must bubble only once.
        cycle(1, mk(OP_LD, 5'd3, 5'd1, 5'd0), 0, 0);
        cycle(1, mk(OP_ALU, 5'd4, 5'd3, 5'd2), 0, 0);
        cycle(1, mk(OP_ALU, 5'd4, 5'd3, 5'd2), 0, 0);
        cycle(1, nop, 0, 0);
        // Same encodings as the original bring-up vectors.
        cycle(1, 32'h50610000, 0, 0);
        cycle(1, 32'h04861000, 0, 0);
        // Load-use through B on a store.
        cycle(1, mk(OP_LD, 5'd5, 5'd0, 5'd0), 0, 0);
        cycle(1, mk(OP_ST, 5'd0, 5'd1, 5'd5), 0, 0);
        cycle(1, mk(OP_ST, 5'd0, 5'd1, 5'd5), 0, 0);
        // r0 never hazards; dependency two slots away never hazards.
        cycle(1, 32'h50010000, 0, 0);
        cycle(1, mk(OP_ALU, 5'd1, 5'd0, 5'd0), 0, 0);
        cycle(1, mk(OP_LD, 5'd3, 5'd0, 5'd0), 0, 0);
        cycle(1, mk(OP_ALU, 5'd2, 5'd1, 5'd1), 0, 0);
        cycle(1, mk(OP_ALU, 5'd2, 5'd3, 5'd3), 0, 0);
        // Jumps do not consume registers.
        cycle(1, mk(OP_LD, 5'd2, 5'd0, 5'd0), 0, 0);
        cycle(1, mk(OP_CJ, 5'd0, 5'd2, 5'd2), 0, 0);
        cycle(1, nop, 0, 0);

        // Unconditional jump.
        cycle(1, 32'h60000010, 0, 0);
        repeat (3) cycle(1, nop, 0, 0);

        // Taken branch coincident with a load-use hazard.
        cycle(1, mk(OP_LD, 5'd3, 5'd0, 5'd0), 0, 0);
        cycle(1, mk(OP_ALU, 5'd1, 5'd3, 5'd0), 1, 0);
        repeat (4) cycle(1, mk(OP_ALU, 5'd1, 5'd3, 5'd0), 0, 0);

        // Taken branch inside a jump squash window.
        cycle(1, 32'h60000020, 0, 0);
        cycle(1, nop, 1, 0);
        repeat (4) cycle(1, nop, 0, 0);

        // Full halt, then release.
        repeat (8) cycle(1, nop, 0, 1);
        repeat (3) cycle(1, nop, 0, 0);
        // Halt abandoned mid-drain; branch during drain ignored.
        repeat (2) cycle(1, nop, 0, 1);
        cycle(1, nop, 0, 0);
        cycle(1, nop, 0, 1);
        cycle(1, nop, 1, 1);
        repeat (6) cycle(1, nop, 0, 1);
        cycle(1, nop, 0, 0);
        // Reset mid-drain.
        repeat (3) cycle(1, nop, 0, 1);
        cycle(0, nop, 0, 1);
        repeat (3) cycle(1, nop, 0, 0);

        // Randomized traffic with small register space to provoke hazards.
        rhr = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: rop = OP_LD;
                3:       rop = OP_ST;
                4:       rop = OP_JMP;
                5:       rop = OP_CJ;
                6, 7, 8: rop = OP_ALU;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            ri = {rop, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 11'($urandom_range(0, 2047))};
            if ($urandom_range(0, 19) == 0) rhr = !rhr;
            cycle($urandom_range(0, 149) != 0, ri, $urandom_range(0, 9) == 0, rhr);
        end

        // Drive stall_cnt into saturation: every cycle alternates RUN(halt) / DRAIN(release).
        cycle(0, nop, 0, 0);
        for (int k = 0; k < 32800; k++) begin
            cycle(1, nop, 0, 1);
            cycle(1, nop, 0, 0);
        end
        // Long halt and some hazards while saturated.
        repeat (12) cycle(1, nop, 0, 1);
        cycle(1, nop, 0, 0);
        cycle(1, mk(OP_LD, 5'd1, 5'd0, 5'd0), 0, 0);
        cycle(1, mk(OP_ALU, 5'd2, 5'd1, 5'd0), 0, 0);
        repeat (3) cycle(1, nop, 0, 0);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queue: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
